// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a two-entry skid buffer, synchronous flush and a stall counter.
// Latency: one cycle from in_fire to out_valid. Sustained throughput is one entry per cycle.
// Backpressure: in_ready is registered (state != TWO), so out_ready never reaches in_ready combinationally.
module pipe_stage_skid_reg #(
  parameter int DATA_W              = 160,
  parameter int EXC_W               = 5,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b1,
  parameter int STALL_CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [EXC_W-1:0]       in_exc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [EXC_W-1:0]       out_exc,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // The state encoding is also the entry count, so occupancy comes straight from the state register.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic [DATA_W-1:0]      main_dat_q, main_dat_d;
  logic [EXC_W-1:0]       main_exc_q, main_exc_d;
  logic [DATA_W-1:0]      skid_dat_q, skid_dat_d;
  logic [EXC_W-1:0]       skid_exc_q, skid_exc_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;
  logic stalled;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_dat_q;
  assign out_exc   = main_exc_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;
  assign stalled  = out_valid & ~out_ready;

  // Next-state and datapath steering; flush overrides the normal handshake result.
  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    main_exc_d = main_exc_q;
    skid_dat_d = skid_dat_q;
    skid_exc_d = skid_exc_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_dat_d = in_data;
          main_exc_d = in_exc;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_dat_d = in_data;
          main_exc_d = in_exc;
        end else if (in_fire) begin
          // Downstream stalled while a new entry arrived: park it in the skid slot.
          skid_dat_d = in_data;
          skid_exc_d = in_exc;
          state_d    = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          main_dat_d = skid_dat_q;
          main_exc_d = skid_exc_q;
          state_d    = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_DATA_ON_FLUSH) begin
        main_dat_d = '0;
        main_exc_d = '0;
        skid_dat_d = '0;
        skid_exc_d = '0;
      end
    end
  end

  // in_ready for the next cycle is derived from the next state, which keeps it a pure register output.
  always_comb begin
    in_ready_d = (state_d != TWO);
  end

  // Saturating stall counter; flush does not touch it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stalled && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // State and storage registers; reset clears everything including the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_dat_q  <= '0;
      main_exc_q  <= '0;
      skid_dat_q  <= '0;
      skid_exc_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_dat_q  <= main_dat_d;
      main_exc_q  <= main_exc_d;
      skid_dat_q  <= skid_dat_d;
      skid_exc_q  <= skid_exc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Randomised and directed bench for pipe_stage_skid_reg with a queue-based reference model.
// Accepted entries are pushed on the edge they fire and popped by a negedge monitor on delivery.
// The monitor compares occupancy, ready, valid, payload and stall count against the model every cycle.
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 160;
  localparam int EXC_W  = 5;
  localparam int SCW    = 4;
  localparam int ENT_W  = DATA_W + EXC_W;
  localparam int SAT    = (1 << SCW) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [EXC_W-1:0]  in_exc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [EXC_W-1:0]  out_exc;
  logic [1:0]        occupancy;
  logic [SCW-1:0]    stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: ordered list of held entries, the value the output register should show, and the stall count.
  logic [ENT_W-1:0] sb[$];
  logic [ENT_W-1:0] main_exp = '0;
  int               stall_exp = 0;
  bit               armed = 1'b0;

  pipe_stage_skid_reg #(
    .DATA_W(DATA_W),
    .EXC_W(EXC_W),
    .CLEAR_DATA_ON_FLUSH(1'b1),
    .STALL_CNT_W(SCW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_exc(in_exc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_exc(out_exc),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [ENT_W-1:0] act, input logic [ENT_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus side of the scoreboard: record every entry accepted on this edge.
  always @(posedge clk) begin
    if (!reset && !flush && in_valid && in_ready) sb.push_back({in_exc, in_data});
  end

  // Monitor: compare DUT against the model, then account for what the coming edge will do.
  always @(negedge clk) begin
    if (armed) begin
      if (sb.size() > 0) main_exp = sb[0];
      chk("occupancy", ENT_W'(occupancy), ENT_W'(sb.size()));
      chk("in_ready",  ENT_W'(in_ready),  ENT_W'(sb.size() < 2));
      chk("out_valid", ENT_W'(out_valid), ENT_W'(sb.size() != 0));
      chk("out_payload", {out_exc, out_data}, main_exp);
      chk("stall_cnt", ENT_W'(stall_cnt), ENT_W'(stall_exp));
    end
    if (reset) begin
      sb.delete();
      main_exp  = '0;
      stall_exp = 0;
      armed     = 1'b1;
    end else begin
      if (sb.size() != 0 && !out_ready && stall_exp != SAT) stall_exp++;
      if (flush) begin
        sb.delete();
        main_exp = '0;
      end else if (sb.size() != 0 && out_ready) begin
        void'(sb.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one entry and hold it until the stage accepts it (bounded wait).
  task automatic send(input logic [DATA_W-1:0] d, input logic [EXC_W-1:0] e);
    bit ok;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_exc   = e;
    for (int i = 0; i < 64 && !done; i++) begin
      ok = in_ready;
      cyc();
      if (ok) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: entry %h not accepted within 64 cycles", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = DATA_W'(8'hAB);
    in_exc   = '0;
    repeat (2) cyc();
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset with a valid entry presented: nothing may be captured.
    do_reset();
    chk("rst_out_valid", ENT_W'(out_valid), '0);
    chk("rst_in_ready",  ENT_W'(in_ready),  ENT_W'(1));
    chk("rst_occupancy", ENT_W'(occupancy), '0);
    chk("rst_payload",   {out_exc, out_data}, '0);
    chk("rst_stall_cnt", ENT_W'(stall_cnt), '0);

    // Streaming 1..8 with downstream always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(DATA_W'(i), EXC_W'(i));
      chk("stream_data", ENT_W'(out_data), ENT_W'(i));
      chk("stream_in_ready", ENT_W'(in_ready), ENT_W'(1));
    end
    repeat (2) cyc();

    // Backpressure: 1 and 2 fill main and skid, 3 waits upstream.
    do_reset();
    out_ready = 1'b0;
    send(DATA_W'(1), EXC_W'(1));
    send(DATA_W'(2), EXC_W'(2));
    in_valid = 1'b1;
    in_data  = DATA_W'(3);
    in_exc   = EXC_W'(3);
    repeat (4) cyc();
    chk("bp_in_ready",  ENT_W'(in_ready),  '0);
    chk("bp_occupancy", ENT_W'(occupancy), ENT_W'(2));
    chk("bp_stall_cnt", ENT_W'(stall_cnt), ENT_W'(5));
    chk("bp_head",      ENT_W'(out_data),  ENT_W'(1));
    out_ready = 1'b1;
    send(DATA_W'(3), EXC_W'(3));
    repeat (4) cyc();
    chk("bp_drained", ENT_W'(occupancy), '0);

    // Flush while two entries are held, with a new entry presented the same cycle.
    do_reset();
    out_ready = 1'b0;
    send(DATA_W'(5), EXC_W'(5'h0C));
    send(DATA_W'(6), EXC_W'(5'h0C));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = DATA_W'(7);
    in_exc   = EXC_W'(1);
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", ENT_W'(out_valid), '0);
    chk("fl_occupancy", ENT_W'(occupancy), '0);
    chk("fl_payload",   {out_exc, out_data}, '0);
    chk("fl_in_ready",  ENT_W'(in_ready),  ENT_W'(1));
    out_ready = 1'b1;
    send(DATA_W'(8), EXC_W'(2));
    chk("fl_next_entry", {out_exc, out_data}, {EXC_W'(2), DATA_W'(8)});
    repeat (2) cyc();

    // Saturation of the 4-bit stall counter; flush keeps it, reset clears it.
    do_reset();
    out_ready = 1'b0;
    send(DATA_W'(9), EXC_W'(0));
    repeat (20) cyc();
    chk("sat_cnt", ENT_W'(stall_cnt), ENT_W'(SAT));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("sat_after_flush", ENT_W'(stall_cnt), ENT_W'(SAT));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("sat_after_reset", ENT_W'(stall_cnt), '0);

    // Random traffic with occasional flushes.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_exc    = EXC_W'($urandom_range(0, 31));
      cyc();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();
    chk("final_empty", ENT_W'(occupancy), '0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
